instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage upstream of the single-cycle control unit: owns the PC, fetches
//  instructions from instruction memory over a req/ready/rvalid handshake, and
//  presents {instr, pc, pc+4} to decode under a valid/ready handshake.
//  Decode takes opcode = if_instr[31:26]. The datapath resolves beq/jmp and
//  returns a redirect (target PC) that flushes in-flight work.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset; bits [1:0] must be 0
// PORTS
//  clk           in   1   clock, all state updates on rising edge
//  rst           in   1   synchronous, active-high reset
//  imem_req      out  1   fetch request valid
//  imem_addr     out  32  fetch address (word aligned)
//  imem_ready    in   1   memory accepts request this cycle (req && ready)
//  imem_rvalid   in   1   read data valid (>=1 cycle after acceptance)
//  imem_rdata    in   32  instruction word
//  if_valid      out  1   if_instr/if_pc/if_pc4 hold a valid instruction
//  if_instr      out  32  fetched instruction
//  if_pc         out  32  address of if_instr
//  if_pc4        out  32  if_pc + 4 (branch base)
//  id_ready      in   1   decode consumes output when if_valid && id_ready
//  redir_valid   in   1   redirect pulse (taken beq or jmp)
//  redir_target  in   32  new PC; bits [1:0] forced to 0
// BEHAVIOUR
//  - Reset: pc=RESET_PC, state=FETCH, if_valid=0, if_instr=if_pc=if_pc4=0,
//    imem_req=0 while rst=1. No memory access outstanding after reset.
//  - States: FETCH (may issue request), WAIT (one request outstanding),
//    DISCARD (outstanding response must be dropped). Max one outstanding.
//  - imem_req = (state==FETCH) && !redir_valid && (!if_valid || id_ready);
//    imem_addr = pc. Accepted (req && ready): FETCH->WAIT.
//  - WAIT, imem_rvalid: if_instr<=rdata, if_pc<=pc, if_pc4<=pc+4, if_valid<=1,
//    pc<=pc+4, ->FETCH. Accept-to-if_valid latency = mem latency + 1 cycle;
//    zero-wait memory gives one instruction per 2 cycles.
//  - Output register: if_valid && id_ready && no new response -> if_valid<=0.
//    if_valid && !id_ready -> all if_* held stable, no new request issued.
//  - Redirect (highest priority, any state): pc<={redir_target[31:2],2'b00};
//    if_valid<=0 next cycle regardless of id_ready.
//      FETCH: request suppressed this cycle, stay FETCH.
//      WAIT, no rvalid same cycle: ->DISCARD. WAIT, rvalid same cycle: data
//      dropped, ->FETCH. DISCARD: stay DISCARD, target updated.
//  - DISCARD, imem_rvalid: data dropped, ->FETCH.
//  - imem_rvalid in FETCH (stray, e.g. after reset) ignored, no state change.
//  - PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
//  - Reset mid-operation overrides everything; a response arriving after reset
//    lands in FETCH and is ignored.
// TESTING
//  1 RESET_PC=0x0040_0000, rst 2 cycles -> if_valid=0; first cycle after
//    release imem_req=1, imem_addr=0x0040_0000.
//  2 Zero-wait mem (ready=1, rvalid next cycle), id_ready=1, rdata=0x2008_0005
//    -> if_valid 2 cycles after accept, if_pc=0x0040_0000, if_pc4=0x0040_0004;
//    request sequence 0x..00,0x..04,0x..08.
//  3 id_ready=0 for 5 cycles with if_valid=1 -> if_* stable, imem_req=0;
//    id_ready=1 -> next request at if_pc+4.
//  4 Redirect 0x0040_0040 while WAIT on 0x0040_0008, rvalid 2 cycles later
//    with 0xDEAD_BEEF -> value never on if_instr; next imem_addr=0x0040_0040.
//  5 Redirect 0x0040_0043 same cycle as rvalid, if_valid=1, id_ready=0
//    -> if_valid=0 next cycle, response dropped, next imem_addr=0x0040_0040.
//  6 pc=0xFFFF_FFFC fetched -> next imem_addr=0x0000_0000; rst in WAIT then
//    stray rvalid -> ignored, first request at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Fetch stage. Owns the PC, issues one instruction-memory read at a time
//   over a req/ready/rvalid handshake, and presents {instr, pc, pc+4} to
//   decode under a valid/ready handshake. A redirect from the datapath
//   (taken beq / jmp) reloads the PC and flushes whatever is in flight.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   imem_req        fetch request valid
//   imem_addr       fetch address (word aligned, equals PC)
//   imem_ready      memory accepts the request this cycle
//   imem_rvalid     read data valid for the outstanding request
//   imem_rdata      instruction word
//   if_valid        if_instr/if_pc/if_pc4 hold a valid instruction
//   if_instr        fetched instruction
//   if_pc           address of if_instr
//   if_pc4          if_pc + 4
//   id_ready        decode consumes the output when if_valid && id_ready
//   redir_valid     redirect pulse
//   redir_target    new PC (bits [1:0] ignored)
//
// State     | meaning
// ----------+-----------------------------------------------------------
// S_FETCH   | no request outstanding; may issue one
// S_WAIT    | one request outstanding, its response will be captured
// S_DISCARD | one request outstanding, its response will be dropped
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    input  logic        id_ready,
    input  logic        redir_valid,
    input  logic [31:0] redir_target
);

    localparam logic [1:0] S_FETCH   = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    logic [1:0]  state_q,    state_d;
    logic [31:0] pc_q,       pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q,    if_pc_d;
    logic [31:0] if_pc4_q,   if_pc4_d;

    // A new request is only issued when the output register is free or is
    // being emptied this cycle, so a stalled decode never loses an instruction.
    always_comb begin
        imem_req  = (state_q == S_FETCH) && !redir_valid
                    && (!if_valid_q || id_ready) && !rst;
        imem_addr = pc_q;
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        if_pc4_d   = if_pc4_q;

        if (redir_valid) begin
            pc_d       = redir_target & ~32'h3;
            if_valid_d = 1'b0;
            case (state_q)
                // A response landing together with the redirect belongs to
                // the old path; with nothing left outstanding we can refetch.
                S_WAIT:    state_d = imem_rvalid ? S_FETCH : S_DISCARD;
                S_DISCARD: state_d = imem_rvalid ? S_FETCH : S_DISCARD;
                default:   state_d = S_FETCH;
            endcase
        end else begin
            if (if_valid_q && id_ready) begin
                if_valid_d = 1'b0;
            end
            case (state_q)
                S_FETCH: begin
                    if (imem_req && imem_ready) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if_instr_d = imem_rdata;
                        if_pc_d    = pc_q;
                        if_pc4_d   = pc_q + 32'd4;
                        if_valid_d = 1'b1;
                        pc_d       = pc_q + 32'd4;
                        state_d    = S_FETCH;
                    end
                end
                S_DISCARD: begin
                    if (imem_rvalid) begin
                        state_d = S_FETCH;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            if_instr_q <= 32'h0;
            if_pc_q    <= 32'h0;
            if_pc4_q   <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            if_pc4_q   <= if_pc4_d;
        end
    end

    assign if_valid = if_valid_q;
    assign if_instr = if_instr_q;
    assign if_pc    = if_pc_q;
    assign if_pc4   = if_pc4_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic        id_ready = 1'b0;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_target = 32'h0;

    instr_fetch_unit #(.RESET_PC(RPC)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .if_pc4       (if_pc4),
        .id_ready     (id_ready),
        .redir_valid  (redir_valid),
        .redir_target (redir_target)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a PC, at most one outstanding fetch tagged with the
    // redirect epoch it was issued in, and the presented instruction.
    logic [31:0] m_pc = RPC;
    logic [31:0] m_req_addr = 32'h0;
    int          m_epoch = 0;
    int          m_req_epoch = 0;
    bit          m_busy = 1'b0;
    bit          m_v = 1'b0;
    logic [31:0] m_instr = 32'h0;
    logic [31:0] m_ipc = 32'h0;
    logic [31:0] m_ipc4 = 32'h0;
    bit          exp_req;

    // Memory: one request at a time, response lat cycles after acceptance.
    bit          mem_pend = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_data = 32'h0;
    int          lat = 1;
    bit          rdy_want = 1'b1;
    bit          stray = 1'b0;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        if (a == 32'h0040_0000) return 32'h2008_0005;
        if (a == 32'h0040_0008) return 32'hDEAD_BEEF;
        return {a[15:0] ^ 16'h1357, a[31:16] ^ 16'hC0DE};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Called just after a falling edge with the control inputs already set;
    // returns just after the next falling edge.
    task automatic cycle();
        imem_ready = rdy_want && !mem_pend;
        if (mem_pend && mem_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_data;
        end else if (stray && !mem_pend) begin
            imem_rvalid = 1'b1;
            imem_rdata  = $urandom;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        exp_req = !rst && !m_busy && !redir_valid && (!m_v || id_ready);
        #1;
        chk("imem_req", {31'h0, imem_req}, {31'h0, exp_req});
        if (exp_req) chk("imem_addr", imem_addr, m_pc);
        @(posedge clk);
        if (imem_rvalid && mem_pend) mem_pend = 1'b0;
        else if (mem_pend) mem_cnt--;
        if (exp_req && imem_ready) begin
            mem_pend = 1'b1;
            mem_cnt  = lat - 1;
            mem_data = memfn(m_pc);
        end
        if (rst) begin
            m_pc = RPC; m_busy = 1'b0; m_v = 1'b0;
            m_instr = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0;
        end else if (redir_valid) begin
            m_pc = redir_target & ~32'h3;
            m_v = 1'b0;
            m_epoch++;
            if (m_busy && imem_rvalid) m_busy = 1'b0;
        end else begin
            if (m_v && id_ready) m_v = 1'b0;
            if (m_busy && imem_rvalid) begin
                m_busy = 1'b0;
                if (m_req_epoch == m_epoch) begin
                    m_instr = imem_rdata;
                    m_ipc   = m_req_addr;
                    m_ipc4  = m_req_addr + 32'd4;
                    m_pc    = m_req_addr + 32'd4;
                    m_v     = 1'b1;
                end
            end else if (exp_req && imem_ready) begin
                m_busy      = 1'b1;
                m_req_addr  = m_pc;
                m_req_epoch = m_epoch;
            end
        end
        @(negedge clk);
        chk("if_valid", {31'h0, if_valid}, {31'h0, m_v});
        if (m_v) begin
            chk("if_instr", if_instr, m_instr);
            chk("if_pc", if_pc, m_ipc);
            chk("if_pc4", if_pc4, m_ipc4);
        end
    endtask

    initial begin
        @(negedge clk);
        // reset
        rst = 1'b1; id_ready = 1'b1; rdy_want = 1'b1; lat = 1;
        repeat (2) cycle();
        chk("rst_if_valid", {31'h0, if_valid}, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_pc4", if_pc4, 32'h0);
        rst = 1'b0;
        #1;
        chk("t1_req", {31'h0, imem_req}, 32'h1);
        chk("t1_addr", imem_addr, 32'h0040_0000);

        // zero-wait memory
        cycle();
        chk("t2_lat", {31'h0, if_valid}, 32'h0);
        cycle();
        chk("t2_valid", {31'h0, if_valid}, 32'h1);
        chk("t2_instr", if_instr, 32'h2008_0005);
        chk("t2_pc", if_pc, 32'h0040_0000);
        chk("t2_pc4", if_pc4, 32'h0040_0004);
        #1;
        chk("t2_addr1", imem_addr, 32'h0040_0004);
        cycle();
        cycle();
        chk("t2_pc_b", if_pc, 32'h0040_0004);

        // decode stall
        id_ready = 1'b0;
        repeat (5) cycle();
        chk("t3_valid", {31'h0, if_valid}, 32'h1);
        chk("t3_pc", if_pc, 32'h0040_0004);
        #1;
        chk("t3_req_stall", {31'h0, imem_req}, 32'h0);
        id_ready = 1'b1;
        #1;
        chk("t3_req", {31'h0, imem_req}, 32'h1);
        chk("t3_addr", imem_addr, 32'h0040_0008);

        // redirect while waiting, late response dropped
        lat = 2;
        cycle();
        redir_valid = 1'b1; redir_target = 32'h0040_0040;
        cycle();
        redir_valid = 1'b0;
        cycle();
        chk("t4_valid", {31'h0, if_valid}, 32'h0);
        #1;
        chk("t4_req", {31'h0, imem_req}, 32'h1);
        chk("t4_addr", imem_addr, 32'h0040_0040);

        // redirect coinciding with the response
        lat = 1;
        cycle();
        redir_valid = 1'b1; redir_target = 32'h0040_0043; id_ready = 1'b0;
        cycle();
        redir_valid = 1'b0;
        chk("t5_valid", {31'h0, if_valid}, 32'h0);
        #1;
        chk("t5_req", {31'h0, imem_req}, 32'h1);
        chk("t5_addr", imem_addr, 32'h0040_0040);
        cycle();
        cycle();
        chk("t5_held", {31'h0, if_valid}, 32'h1);
        redir_valid = 1'b1; redir_target = 32'h0040_0103;
        cycle();
        redir_valid = 1'b0;
        chk("t5_flush", {31'h0, if_valid}, 32'h0);
        #1;
        chk("t5_addr2", imem_addr, 32'h0040_0100);

        // PC wrap, then reset with a response still in flight
        redir_valid = 1'b1; redir_target = 32'hFFFF_FFFF;
        cycle();
        redir_valid = 1'b0; id_ready = 1'b1;
        cycle();
        cycle();
        chk("t6_pc", if_pc, 32'hFFFF_FFFC);
        chk("t6_pc4", if_pc4, 32'h0000_0000);
        #1;
        chk("t6_addr", imem_addr, 32'h0000_0000);
        lat = 3;
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        chk("t6_valid", {31'h0, if_valid}, 32'h0);
        #1;
        chk("t6_req", {31'h0, imem_req}, 32'h1);
        chk("t6_rpc", imem_addr, RPC);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst          = ($urandom_range(99) == 0);
            id_ready     = ($urandom_range(9) < 7);
            rdy_want     = ($urandom_range(9) < 6);
            redir_valid  = ($urandom_range(15) == 0);
            redir_target = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15))
                                                     : $urandom;
            lat          = $urandom_range(1, 3);
            stray        = ($urandom_range(19) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
